// File: rtl/spike_enc_pkg.sv
// Shared types and constants for the spike-time encoder.
// Build option: SPIKE_ENC_NOSPIKE_EN (top code value means "no spike").
package spike_enc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2
  } enc_state_t;

  localparam int ENC_INPUT_SIZE = 32;
  localparam int ENC_T_BITS     = 3;
  localparam int GAMMA_LEN      = 2 ** ENC_T_BITS;
  localparam int NOSPIKE_CODE   = GAMMA_LEN - 1;

endpackage

// File: rtl/spike_line_gen.sv
// One spike line: latched code, slot compare, registered output.
// Build option: SPIKE_ENC_NOSPIKE_EN (top code value never fires).
module spike_line_gen
  import spike_enc_pkg::*;
#(
  parameter int T_BITS = ENC_T_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              advance,
  input  logic [T_BITS-1:0] load_code,
  input  logic [T_BITS-1:0] next_slot,
  output logic              spike
);

  localparam logic [T_BITS-1:0] NOSPIKE = '1;

  logic [T_BITS-1:0] code_q;
  logic [T_BITS-1:0] cmp_code;
  logic [T_BITS-1:0] cmp_slot;
  logic              fire;

  // On load the first visible slot is 0, compared against the new code.
  always_comb begin
    cmp_code = load ? load_code : code_q;
    cmp_slot = load ? '0 : next_slot;
    fire     = (cmp_slot >= cmp_code);
`ifdef SPIKE_ENC_NOSPIKE_EN
    if (cmp_code == NOSPIKE) begin
      fire = 1'b0;
    end
`else
    if (cmp_code == NOSPIKE) begin
      fire = (cmp_slot == NOSPIKE);
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_q <= '0;
      spike  <= 1'b1;
    end else begin
      if (load) begin
        code_q <= load_code;
      end
      if (load || advance) begin
        spike <= ~fire;
      end else begin
        spike <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/spike_time_encoder.sv
// Spike-time encoder: one gamma cycle of 1->0 events per vector.
// Build option: SPIKE_ENC_NOSPIKE_EN (top code value means "no spike").
module spike_time_encoder
  import spike_enc_pkg::*;
#(
  parameter int INPUT_SIZE = ENC_INPUT_SIZE,
  parameter int T_BITS     = ENC_T_BITS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [INPUT_SIZE*T_BITS-1:0] in_times,
  output logic                         in_ready,
  output logic [0:INPUT_SIZE-1]        spike_out,
  output logic                         gamma_start,
  output logic                         busy
);

  localparam logic [T_BITS-1:0] LAST = '1;

  enc_state_t        state_q;
  enc_state_t        state_d;
  logic [T_BITS-1:0] slot_q;
  logic [T_BITS-1:0] slot_d;
  logic [T_BITS-1:0] slot_nx;
  logic              transfer;
  logic              advance;

  assign in_ready = (state_q != ST_RUN);
  assign transfer = in_valid && in_ready;
  assign slot_nx  = slot_q + T_BITS'(1);
  assign advance  = (state_q == ST_RUN) && (slot_q != LAST);

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    unique case (state_q)
      ST_IDLE: begin
        if (transfer) begin
          state_d = ST_RUN;
          slot_d  = '0;
        end
      end
      ST_RUN: begin
        slot_d = slot_nx;
        if (slot_q == LAST) begin
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        slot_d  = '0;
        state_d = transfer ? ST_RUN : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        slot_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      slot_q      <= '0;
      gamma_start <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      gamma_start <= transfer;
      busy        <= (state_d != ST_IDLE);
    end
  end

  for (genvar i = 0; i < INPUT_SIZE; i++) begin : g_line
    spike_line_gen #(
      .T_BITS(T_BITS)
    ) u_line (
      .clk      (clk),
      .rst      (rst),
      .load     (transfer),
      .advance  (advance),
      .load_code(in_times[i*T_BITS +: T_BITS]),
      .next_slot(slot_nx),
      .spike    (spike_out[i])
    );
  end

endmodule

// File: tb/tb_spike_time_encoder.sv
// Directed bench for spike_time_encoder (default 32 lines, 3-bit codes).
module tb_spike_time_encoder;

  localparam int N  = 32;
  localparam int TB = 3;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic [N*TB-1:0] in_times;
  logic            in_ready;
  logic [0:N-1]    spike_out;
  logic            gamma_start;
  logic            busy;

  int total;
  int bad;

  spike_time_encoder #(
    .INPUT_SIZE(N),
    .T_BITS    (TB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_times   (in_times),
    .in_ready   (in_ready),
    .spike_out  (spike_out),
    .gamma_start(gamma_start),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N*TB-1:0] vec_ramp();
    logic [N*TB-1:0] v;
    for (int i = 0; i < N; i++) v[i*TB +: TB] = TB'(i % 8);
    return v;
  endfunction

  function automatic logic [N*TB-1:0] vec_rev();
    logic [N*TB-1:0] v;
    for (int i = 0; i < N; i++) v[i*TB +: TB] = TB'(7 - (i % 8));
    return v;
  endfunction

  function automatic logic [N*TB-1:0] vec_fill(input int c);
    logic [N*TB-1:0] v;
    for (int i = 0; i < N; i++) v[i*TB +: TB] = TB'(c);
    return v;
  endfunction

  function automatic logic [0:N-1] exp_lines(input logic [N*TB-1:0] t, input int s);
    logic [0:N-1] e;
    int c;
    for (int i = 0; i < N; i++) begin
      c = int'(t[i*TB +: TB]);
      e[i] = !(s >= c);
`ifdef SPIKE_ENC_NOSPIKE_EN
      if (c == 7) e[i] = 1'b1;
`endif
    end
    return e;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_times = '0;
    #3;
    total++;
    if (spike_out !== '1) begin
      bad++;
      $display("FAIL reset_spike got=%h exp=%h", spike_out, 32'hffffffff);
    end
    total++;
    if (busy !== 1'b0 || gamma_start !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ctrl got busy=%b gs=%b rdy=%b exp 0 0 1",
               busy, gamma_start, in_ready);
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
    total++;
    if (spike_out !== '1 || busy !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL idle_after_reset got sp=%h busy=%b rdy=%b", spike_out, busy, in_ready);
    end
  endtask

  task automatic test_ramp();
    logic [N*TB-1:0] v;
    logic [0:N-1] e;
    v = vec_ramp();
    in_times = v;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_times = vec_fill(0);
    for (int s = 0; s < 8; s++) begin
      e = exp_lines(v, s);
      total++;
      if (spike_out !== e) begin
        bad++;
        $display("FAIL ramp_slot%0d got=%h exp=%h", s, spike_out, e);
      end
      total++;
      if (gamma_start !== (s == 0) || busy !== 1'b1 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL ramp_ctrl%0d got gs=%b busy=%b rdy=%b", s, gamma_start, busy, in_ready);
      end
      if (s == 0) begin
        total++;
        if (spike_out[0] !== 1'b0 || spike_out[1] !== 1'b1) begin
          bad++;
          $display("FAIL ramp_line0 got l0=%b l1=%b exp 0 1", spike_out[0], spike_out[1]);
        end
      end
      if (s == 5 || s == 6) begin
        total++;
        if (spike_out[6] !== (s == 5)) begin
          bad++;
          $display("FAIL ramp_line6_s%0d got=%b exp=%b", s, spike_out[6], s == 5);
        end
      end
      if (s == 7) begin
        total++;
`ifdef SPIKE_ENC_NOSPIKE_EN
        if (spike_out[7] !== 1'b1) begin
          bad++;
          $display("FAIL line7_nospike got=%b exp=1", spike_out[7]);
        end
`else
        if (spike_out[7] !== 1'b0) begin
          bad++;
          $display("FAIL line7_last got=%b exp=0", spike_out[7]);
        end
`endif
      end
      tick();
    end
    total++;
    if (spike_out !== '1 || busy !== 1'b1 || in_ready !== 1'b1 || gamma_start !== 1'b0) begin
      bad++;
      $display("FAIL ramp_gap got sp=%h busy=%b rdy=%b gs=%b", spike_out, busy, in_ready, gamma_start);
    end
    tick();
    total++;
    if (busy !== 1'b0 || spike_out !== '1) begin
      bad++;
      $display("FAIL ramp_idle got busy=%b sp=%h exp 0 ffffffff", busy, spike_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [N*TB-1:0] va;
    logic [N*TB-1:0] vb;
    logic [0:N-1] e;
    int s;
    va = vec_ramp();
    vb = vec_rev();
    in_times = va;
    in_valid = 1'b1;
    tick();
    for (int c = 0; c < 18; c++) begin
      s = c % 9;
      e = (s == 8) ? '1 : exp_lines((c < 9) ? va : vb, s);
      total++;
      if (spike_out !== e || in_ready !== (s == 8)) begin
        bad++;
        $display("FAIL b2b_lines c=%0d got=%h rdy=%b exp=%h rdy=%b", c, spike_out, in_ready, e, s == 8);
      end
      total++;
      if (gamma_start !== (s == 0) || busy !== 1'b1) begin
        bad++;
        $display("FAIL b2b_ctrl c=%0d got gs=%b busy=%b exp gs=%b busy=1", c, gamma_start, busy, s == 0);
      end
      if (c == 8) in_times = vb;
      if (c == 17) in_valid = 1'b0;
      tick();
    end
    total++;
    if (busy !== 1'b0 || gamma_start !== 1'b0) begin
      bad++;
      $display("FAIL b2b_end got busy=%b gs=%b exp 0 0", busy, gamma_start);
    end
  endtask

  task automatic test_ignore_busy();
    logic [0:N-1] e;
    in_times = vec_fill(4);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int s = 0; s < 8; s++) begin
      if (s == 1) begin
        in_valid = 1'b1;
        in_times = vec_fill(0);
        #1;
      end
      if (s == 6) in_valid = 1'b0;
      e = (s >= 4) ? '0 : '1;
      total++;
      if (spike_out !== e || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL ignore_s%0d got=%h rdy=%b exp=%h rdy=0", s, spike_out, in_ready, e);
      end
      tick();
    end
    tick();
    total++;
    if (busy !== 1'b0 || spike_out !== '1) begin
      bad++;
      $display("FAIL ignore_end got busy=%b sp=%h exp 0 ffffffff", busy, spike_out);
    end
  endtask

  task automatic test_mid_reset();
    logic [N*TB-1:0] v;
    in_times = vec_fill(0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    total++;
    if (spike_out !== '0) begin
      bad++;
      $display("FAIL midrst_pre got=%h exp=00000000", spike_out);
    end
    rst = 1'b1;
    #1;
    total++;
    if (spike_out !== '1 || busy !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL midrst_async got sp=%h busy=%b rdy=%b", spike_out, busy, in_ready);
    end
    tick();
    rst = 1'b0;
    tick();
    total++;
    if (spike_out !== '1 || busy !== 1'b0 || gamma_start !== 1'b0) begin
      bad++;
      $display("FAIL midrst_idle got sp=%h busy=%b gs=%b", spike_out, busy, gamma_start);
    end
    v = vec_ramp();
    in_times = v;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int s = 0; s < 2; s++) begin
      total++;
      if (spike_out !== exp_lines(v, s) || gamma_start !== (s == 0)) begin
        bad++;
        $display("FAIL midrst_restart_s%0d got=%h gs=%b exp=%h", s, spike_out, gamma_start, exp_lines(v, s));
      end
      tick();
    end
    repeat (8) tick();
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_ramp();
    test_back_to_back();
    test_ignore_busy();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spike_time_encoder.md
# spike_time_encoder

Converts a vector of binary spike-time codes into 1->0 transition events on parallel lines, one gamma cycle per accepted vector. It is the transmitter side of the spike-time encoding used throughout the design. Its `spike_out` lines drive the 32-line bitonic sorter and other temporal (TNN) consumers directly. Each line idles high and falls at the slot equal to its code.

## Interface
- `INPUT_SIZE`, 32, number of spike lines.
- `T_BITS`, 3, bits per spike-time code; gamma cycle has `2**T_BITS` slots.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  asynchronous, active-high reset.
- `in_valid`  input  1  `in_times` holds a valid vector.
- `in_times`  input  `INPUT_SIZE*T_BITS`  packed codes; line i uses bits `[i*T_BITS +: T_BITS]`.
- `in_ready`  output  1  encoder can accept a vector this cycle.
- `spike_out`  output  `[0:INPUT_SIZE-1]`  event lines; 1 = idle, 1->0 = spike.
- `gamma_start`  output  1  high during slot 0 of each gamma cycle.
- `busy`  output  1  high during RUN and GAP.

## Operation
- FSM states:
  - IDLE: `in_ready=1`, `spike_out` all 1.
  - RUN: slot counter s runs 0..`2**T_BITS-1`.
  - GAP: one cycle, `spike_out` all 1, `in_ready=1`.
- Handshake: transfer occurs on a rising edge with `in_valid && in_ready`. The vector is latched into an internal time register.
- IDLE + transfer -> RUN with s=0. IDLE without transfer -> IDLE.
- RUN increments s each cycle. At s=`2**T_BITS-1` -> GAP.
- GAP + transfer -> RUN with s=0 (back-to-back). GAP without transfer -> IDLE.
- In RUN, line i is driven `spike_out[i]=0` iff s >= code[i], else 1. Each line makes at most one 1->0 transition per gamma cycle and holds low until GAP.
- `in_ready` is a combinational decode of the state. It is 0 in RUN. `in_valid` during RUN is ignored, and the latched codes are unchanged.
- `in_times` is sampled only at transfer. Later changes on it have no effect.
- Comparison is unsigned at `T_BITS` width. The slot counter is `T_BITS` wide and its wrap coincides with the RUN->GAP transition.

## Timing
- Reset values: state IDLE, s=0, `spike_out` all 1, `gamma_start=0`, `busy=0`, `in_ready=1`. Transfers are never taken while `rst` is high.
- `spike_out`, `gamma_start` and `busy` are registered.
- For a transfer at edge k, slot s is visible during the cycle after edge k+s (s=0..`2**T_BITS-1`).
- GAP is visible after edge k+`2**T_BITS`.
- Throughput: one vector per `2**T_BITS+1` cycles with `in_valid` held high.
- Latency from transfer to a code-0 spike: 1 cycle.
- Reset asserted mid-RUN or mid-GAP: all lines return to 1 asynchronously, the FSM returns to IDLE, and the latched codes are discarded.

## Configuration
- `SPIKE_ENC_NOSPIKE_EN` defined: code `2**T_BITS-1` means "no spike". That line stays 1 for the whole gamma cycle.
- Not defined: code `2**T_BITS-1` spikes in the last slot, like any other code.

## Structure
- The shared package `spike_enc_pkg` holds:
  - the state enum typedef (IDLE, RUN, GAP);
  - localparam `GAMMA_LEN = 2**T_BITS`;
  - the no-spike code constant.
- One sub-module, `spike_line_gen`: a per-line code compare plus output register, generated `INPUT_SIZE` times.
- The FSM and slot counter live in the top module.

## Test plan
- Reset: assert `rst` -> `spike_out`=all 1s, `busy=0`, `gamma_start=0`, `in_ready=1`.
- Ramp: transfer at edge k with code[i]=i%8 (defaults) -> line 0 is low from the cycle after edge k. Line 6 falls after edge k+6. `gamma_start` is high only after edge k. All lines return to 1 after edge k+8.
- Code 7 (line 7), macro defined -> stays 1 throughout. Macro not defined -> falls after edge k+7, high again after k+8.
- Back-to-back: `in_valid` held high with distinct vectors -> transfers occur every 9 cycles. `gamma_start` is high at 9-cycle period and `busy` stays high continuously.
- Ignore while busy: new `in_valid`/`in_times` during RUN -> `in_ready=0` and the current gamma pattern is unchanged.
- Mid-run reset: assert `rst` at slot 3 -> `spike_out` is all 1s immediately and IDLE follows. The next transfer after release starts cleanly at s=0.
